// File: rtl/inverter_loop_checker_pkg.sv
// Shared types and default constants for the double-inverter loop checker.
package inverter_test_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        SETTLE = 3'd1,
        RISE   = 3'd2,
        FALL   = 3'd3,
        DONE   = 3'd4
    } state_t;

    localparam int unsigned SYNC_STAGES_DEF = 2;
    localparam int unsigned CNT_W_DEF       = 8;
    localparam int unsigned TIMEOUT_DEF     = 255;

endpackage

// File: rtl/inverter_loop_checker_if.sv
// Control/result bus of the loop checker: the requester drives start/limit, the checker returns status.
interface inverter_loop_checker_if
    import inverter_test_pkg::*;
#(
    parameter int unsigned CNT_W = CNT_W_DEF
);
    logic             start;
    logic [CNT_W-1:0] limit;
    logic             busy;
    logic             done;
    logic             pass;
    logic             timeout;
    logic [CNT_W-1:0] rise_dly;
    logic [CNT_W-1:0] fall_dly;

    modport master (
        output start, limit,
        input  busy, done, pass, timeout, rise_dly, fall_dly
    );

    modport slave (
        input  start, limit,
        output busy, done, pass, timeout, rise_dly, fall_dly
    );
endinterface

// File: rtl/inverter_loop_checker_sync_ff.sv
// Flop-chain synchronizer for an asynchronous single-bit input; resets to 0.
module sync_ff
    import inverter_test_pkg::*;
#(
    parameter int unsigned SYNC_STAGES = SYNC_STAGES_DEF
) (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);
    logic [SYNC_STAGES-1:0] chain;

    always_ff @(posedge clk) begin
        if (rst) begin
            chain <= '0;
        end else begin
            chain <= {chain[SYNC_STAGES-2:0], d};
        end
    end

    assign q = chain[SYNC_STAGES-1];
endmodule

// File: rtl/inverter_loop_checker.sv
// Drives a low-high-low step into the analog double-inverter macro and measures both
// synchronized edge round-trip delays in clock cycles, reporting pass/fail against a limit.
module inverter_loop_checker
    import inverter_test_pkg::*;
#(
    parameter int unsigned SYNC_STAGES = SYNC_STAGES_DEF,
    parameter int unsigned CNT_W       = CNT_W_DEF,
    parameter int unsigned TIMEOUT     = TIMEOUT_DEF
) (
    input  logic                    clk,
    input  logic                    rst,
    inverter_loop_checker_if.slave  bus,
    input  logic                    resp_in,
    output logic                    stim_out
);
    localparam logic [CNT_W-1:0] TO_MAX  = CNT_W'(TIMEOUT);
    localparam logic [CNT_W-1:0] TO_LAST = CNT_W'(TIMEOUT - 1);
    localparam logic [CNT_W-1:0] ONE     = CNT_W'(1);

    state_t           state, state_n;
    logic [CNT_W-1:0] cnt, cnt_n;
    logic [CNT_W-1:0] lim, lim_n;
    logic [CNT_W-1:0] rise_q, rise_n;
    logic [CNT_W-1:0] fall_q, fall_n;
    logic             stim_q, stim_n;
    logic             done_q, done_n;
    logic             pass_q, pass_n;
    logic             timeout_q, timeout_n;
    logic             resp_s;

    sync_ff #(
        .SYNC_STAGES(SYNC_STAGES)
    ) u_resp_sync (
        .clk (clk),
        .rst (rst),
        .d   (resp_in),
        .q   (resp_s)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            cnt       <= '0;
            lim       <= '0;
            rise_q    <= '0;
            fall_q    <= '0;
            stim_q    <= 1'b0;
            done_q    <= 1'b0;
            pass_q    <= 1'b0;
            timeout_q <= 1'b0;
        end else begin
            state     <= state_n;
            cnt       <= cnt_n;
            lim       <= lim_n;
            rise_q    <= rise_n;
            fall_q    <= fall_n;
            stim_q    <= stim_n;
            done_q    <= done_n;
            pass_q    <= pass_n;
            timeout_q <= timeout_n;
        end
    end

    always_comb begin
        state_n   = state;
        cnt_n     = cnt;
        lim_n     = lim;
        rise_n    = rise_q;
        fall_n    = fall_q;
        pass_n    = pass_q;
        timeout_n = timeout_q;

        case (state)
            IDLE: begin
                if (bus.start) begin
                    lim_n     = bus.limit;
                    pass_n    = 1'b0;
                    timeout_n = 1'b0;
                    rise_n    = '0;
                    fall_n    = '0;
                    cnt_n     = '0;
                    state_n   = SETTLE;
                end
            end
            SETTLE: begin
                if (!resp_s) begin
                    cnt_n   = '0;
                    state_n = RISE;
                end else if (cnt == TO_LAST) begin
                    cnt_n     = TO_MAX;
                    timeout_n = 1'b1;
                    state_n   = DONE;
                end else begin
                    cnt_n = cnt + ONE;
                end
            end
            RISE: begin
                if (resp_s) begin
                    rise_n  = cnt;
                    cnt_n   = '0;
                    state_n = FALL;
                end else if (cnt == TO_LAST) begin
                    cnt_n     = TO_MAX;
                    timeout_n = 1'b1;
                    rise_n    = TO_MAX;
                    state_n   = DONE;
                end else begin
                    cnt_n = cnt + ONE;
                end
            end
            FALL: begin
                if (!resp_s) begin
                    fall_n  = cnt;
                    state_n = DONE;
                end else if (cnt == TO_LAST) begin
                    cnt_n     = TO_MAX;
                    timeout_n = 1'b1;
                    fall_n    = TO_MAX;
                    state_n   = DONE;
                end else begin
                    cnt_n = cnt + ONE;
                end
            end
            DONE: begin
                state_n = IDLE;
            end
            default: begin
                state_n = IDLE;
            end
        endcase

        // Outputs are registered from the next state so stim/done/pass line up with the state they belong to.
        stim_n = (state_n == RISE);
        done_n = (state_n == DONE);
        if (state_n == DONE) begin
            pass_n = !timeout_n && (rise_n <= lim_n) && (fall_n <= lim_n);
        end
    end

    assign stim_out     = stim_q;
    assign bus.busy     = (state != IDLE);
    assign bus.done     = done_q;
    assign bus.pass     = pass_q;
    assign bus.timeout  = timeout_q;
    assign bus.rise_dly = rise_q;
    assign bus.fall_dly = fall_q;
endmodule

// File: tb/tb_inverter_loop_checker.sv
// Directed self-checking bench for inverter_loop_checker with a behavioural loop model.
module tb_inverter_loop_checker;
    import inverter_test_pkg::*;

    localparam int unsigned CNT_W = 8;

    logic       clk = 1'b0;
    logic       rst;
    logic       resp_in;
    logic       stim_out;
    logic [7:0] sr = '0;
    int         mode = 0;
    int         stim_hi = 0;
    int         checks = 0;
    int         errors = 0;

    always #5 clk = ~clk;

    inverter_loop_checker_if #(.CNT_W(CNT_W)) bus();

    inverter_loop_checker #(
        .SYNC_STAGES(2),
        .CNT_W(CNT_W),
        .TIMEOUT(255)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .bus      (bus),
        .resp_in  (resp_in),
        .stim_out (stim_out)
    );

    // Loop model: 0 ideal, 1 rise 5 / fall 3 cycles, 2 stuck low, 3 stuck high.
    always @(posedge clk) begin
        sr <= {sr[6:0], stim_out};
        if (stim_out) stim_hi <= stim_hi + 1;
    end

    always_comb begin
        resp_in = 1'b0;
        case (mode)
            0: resp_in = stim_out;
            1: resp_in = sr[2] & sr[4];
            2: resp_in = 1'b0;
            default: resp_in = 1'b1;
        endcase
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic kick(input logic [7:0] lim, input logic hold);
        @(negedge clk);
        bus.limit = lim;
        bus.start = 1'b1;
        @(negedge clk);
        if (!hold) bus.start = 1'b0;
    endtask

    task automatic wait_done(output int cyc);
        cyc = 1;
        while (!bus.done && cyc < 2000) begin
            @(negedge clk);
            cyc++;
        end
        check("done_seen", bus.done, 1);
    endtask

    task automatic idle_cycles(input int n);
        for (int i = 0; i < n; i++) @(negedge clk);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_stim"}, stim_out, 0);
        check({tag, "_busy"}, bus.busy, 0);
        check({tag, "_done"}, bus.done, 0);
        check({tag, "_pass"}, bus.pass, 0);
        check({tag, "_timeout"}, bus.timeout, 0);
        check({tag, "_rise"}, bus.rise_dly, 0);
        check({tag, "_fall"}, bus.fall_dly, 0);
    endtask

    initial begin
        int cyc;
        int stim_before;

        bus.start = 1'b0;
        bus.limit = '0;
        rst       = 1'b1;
        idle_cycles(3);
        rst = 1'b0;
        @(negedge clk);
        check_reset_outputs("reset");

        // Ideal loopback, limit 4.
        kick(8'd4, 1'b0);
        wait_done(cyc);
        check("ideal_latency", cyc, 8);
        check("ideal_rise", bus.rise_dly, 2);
        check("ideal_fall", bus.fall_dly, 2);
        check("ideal_timeout", bus.timeout, 0);
        check("ideal_pass", bus.pass, 1);
        @(negedge clk);
        check("ideal_done_1cyc", bus.done, 0);
        check("ideal_idle", bus.busy, 0);

        // Asymmetric delay: rise 5, fall 3, limit 6.
        mode = 1;
        idle_cycles(4);
        check("hold_pass", bus.pass, 1);
        check("hold_rise", bus.rise_dly, 2);
        kick(8'd6, 1'b0);
        wait_done(cyc);
        check("asym_latency", cyc, 16);
        check("asym_rise", bus.rise_dly, 7);
        check("asym_fall", bus.fall_dly, 5);
        check("asym_timeout", bus.timeout, 0);
        check("asym_pass", bus.pass, 0);

        // Back-to-back: limit 8 latched, then changed to 0 mid-run.
        idle_cycles(5);
        check("b2b_hold_rise", bus.rise_dly, 7);
        check("b2b_hold_fall", bus.fall_dly, 5);
        kick(8'd8, 1'b0);
        bus.limit = 8'd0;
        check("b2b_clr_rise", bus.rise_dly, 0);
        check("b2b_clr_fall", bus.fall_dly, 0);
        check("b2b_busy", bus.busy, 1);
        wait_done(cyc);
        check("b2b_rise", bus.rise_dly, 7);
        check("b2b_fall", bus.fall_dly, 5);
        check("b2b_pass", bus.pass, 1);

        // Response stuck low: rise times out; limit 255 shows timeout alone forces a fail.
        mode = 2;
        idle_cycles(10);
        kick(8'd255, 1'b0);
        wait_done(cyc);
        check("stuck0_latency", cyc, 257);
        check("stuck0_timeout", bus.timeout, 1);
        check("stuck0_rise", bus.rise_dly, 255);
        check("stuck0_fall", bus.fall_dly, 0);
        check("stuck0_pass", bus.pass, 0);
        check("stuck0_stim", stim_out, 0);

        // Response stuck high: settle times out and the stimulus never rises.
        mode = 3;
        idle_cycles(4);
        stim_before = stim_hi;
        kick(8'd255, 1'b0);
        wait_done(cyc);
        check("stuck1_latency", cyc, 256);
        check("stuck1_timeout", bus.timeout, 1);
        check("stuck1_rise", bus.rise_dly, 0);
        check("stuck1_fall", bus.fall_dly, 0);
        check("stuck1_pass", bus.pass, 0);
        check("stuck1_no_stim", stim_hi - stim_before, 0);

        // Start held high: no restart mid-run, one new run per IDLE entry.
        mode = 0;
        idle_cycles(4);
        kick(8'd4, 1'b1);
        wait_done(cyc);
        check("held_latency", cyc, 8);
        check("held_pass", bus.pass, 1);
        @(negedge clk);
        check("held_idle", bus.busy, 0);
        @(negedge clk);
        check("held_rerun", bus.busy, 1);
        bus.start = 1'b0;

        // Reset while in RISE.
        cyc = 0;
        while (!stim_out && cyc < 20) begin
            @(negedge clk);
            cyc++;
        end
        check("rise_reached", stim_out, 1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check_reset_outputs("midrst");
        @(negedge clk);
        check("midrst_stay_idle", bus.busy, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/inverter_loop_checker.md
# inverter_loop_checker

Digital stimulus-and-capture engine for the analog double-inverter macro. It drives the macro's input pin with a controlled low→high→low sequence and samples the macro's output pin through a synchronizer. It measures the rising- and falling-edge round-trip delays in clock cycles and reports pass/fail against a programmable limit. It sits in the digital wrapper of the same tile: `stim_out` feeds the analog input pad and `resp_in` comes back from the analog output pad.

## Interface
Parameters:
- `SYNC_STAGES`, 2: flops in the `resp_in` synchronizer (≥2).
- `CNT_W`, 8: width of delay counters and results.
- `TIMEOUT`, 255: max cycles waited in any measuring state; must be ≤ 2^CNT_W − 1.

Ports:
- `clk`  in  1: sole clock.
- `rst`  in  1: synchronous, active-high reset.
- `start`  in  1: request a measurement; sampled only in IDLE.
- `limit`  in  CNT_W: max acceptable delay for each edge; sampled on accepted `start`.
- `resp_in`  in  1: asynchronous return from the macro output.
- `stim_out`  out  1: registered drive to the macro input.
- `busy`  out  1: high in every state except IDLE.
- `done`  out  1: one-cycle pulse when a run ends.
- `pass`  out  1: result of last run; valid from `done`, held until next accepted `start`.
- `timeout`  out  1: last run aborted on TIMEOUT; held like `pass`.
- `rise_dly`  out  CNT_W: last rising-edge delay.
- `fall_dly`  out  CNT_W: last falling-edge delay.

## Operation
- Reset: FSM→IDLE; `stim_out`, `busy`, `done`, `pass`, `timeout` = 0; `rise_dly`, `fall_dly` = 0; synchronizer flops = 0.
- `resp_s` = `resp_in` after SYNC_STAGES flops. The macro is non-inverting, so the expected `resp_s` equals `stim_out`.
- States: IDLE, SETTLE, RISE, FALL, DONE.
- IDLE: `stim_out`=0.
  - On `start`=1, latch `limit`, clear `pass`/`timeout`/`rise_dly`/`fall_dly`, clear `cnt`, and go to SETTLE.
- SETTLE: `stim_out`=0.
  - `resp_s`=0 → clear `cnt`, go to RISE.
  - Otherwise `cnt`++. Reaching TIMEOUT → set `timeout`, go to DONE.
- RISE: `stim_out`=1 from the first RISE cycle.
  - `resp_s`=1 → `rise_dly`←`cnt`, clear `cnt`, go to FALL.
  - Otherwise `cnt`++. Reaching TIMEOUT → set `timeout`, `rise_dly`←TIMEOUT, go to DONE.
- FALL: `stim_out`=0.
  - `resp_s`=0 → `fall_dly`←`cnt`, go to DONE.
  - TIMEOUT → set `timeout`, `fall_dly`←TIMEOUT, go to DONE.
- DONE: one cycle. `stim_out`=0, `done`=1, `pass` = !`timeout` && `rise_dly` ≤ latched limit && `fall_dly` ≤ latched limit. Then go to IDLE.
- `start` outside IDLE is ignored; no queuing.
- `cnt` never exceeds TIMEOUT (no wrap). Comparisons are unsigned, CNT_W bits.
- `rst` mid-run aborts immediately to the reset values; a partial result is never reported.

## Timing
- `stim_out` changes on the clock edge that enters RISE or FALL. `cnt`=0 in the first cycle of that state.
- Delay = cycles from the first cycle with the new `stim_out` to the first cycle `resp_s` matches it. A zero-delay loopback gives `rise_dly` = `fall_dly` = SYNC_STAGES.
- A response that arrives in analog time d adds ceil(d/Tclk) cycles, ±1 for metastability resolution.
- `start` accepted at edge e0 → SETTLE at e0. With an ideal loop: RISE at e1, FALL at e1+SYNC_STAGES+1, DONE at e1+2·SYNC_STAGES+2, `done` high for one cycle, IDLE on the next edge.
- `busy` = (state ≠ IDLE), decoded from registered state.

## Structure
- Shared package `inverter_test_pkg`:
  - state encoding (IDLE=0, SETTLE=1, RISE=2, FALL=3, DONE=4; 3 bits);
  - default constants SYNC_STAGES_DEF=2, CNT_W_DEF=8, TIMEOUT_DEF=255.
- Sub-module `sync_ff`: parameterized SYNC_STAGES-deep flop chain with synchronous active-high reset to 0. Instantiated once for `resp_in`.
- FSM, counter, and result registers live in `inverter_loop_checker`.

## Test plan
- Zero-delay loopback (`resp_in`=`stim_out`), `limit`=4, pulse `start` → `rise_dly`=2, `fall_dly`=2, `timeout`=0, `pass`=1, single-cycle `done`.
- Bench delay model of 5 cycles rise and 3 cycles fall, `limit`=6 → `rise_dly`=7, `fall_dly`=5, `pass`=0 (fall passes, rise exceeds), `timeout`=0.
- `resp_in` stuck at 0 → RISE times out after 255 cycles: `timeout`=1, `rise_dly`=255, `fall_dly`=0, `pass`=0, `stim_out`=0 in DONE.
- `resp_in` stuck at 1 (or an inverting loop) → SETTLE times out: `timeout`=1, `rise_dly`=`fall_dly`=0, `stim_out` never goes high.
- `start` held high during a run → exactly one run per IDLE entry; assert `rst` for one cycle in RISE → next cycle all outputs at reset values and state IDLE.
- Back-to-back runs with `limit` changed mid-run → the pass decision uses the `limit` latched at accepted `start`; the previous results hold until the new `start`.
